wb_ps2_keyboard: RTL and testbench
==================================

// Module: wb_ps2_keyboard
// PURPOSE
//  Wishbone-style bus slave occupying the Keyboard slot (slave_STB[3]/slave_ACK[3]) of the intercon.
//  Receives PS/2 frames from the keyboard, buffers scan-code bytes in a FIFO and answers CPU
//  reads/writes with a STB/ACK handshake. This is the responder end of the master bus the CPU drives.
// PARAMETERS
//  FIFO_AW         4      log2 FIFO depth (16 entries)
//  TIMEOUT_CYCLES  25000  clk cycles without a PS/2 falling edge mid-frame before abort (1 ms @ 25 MHz)
// PORTS
//  clk       in   1   system clock (clk25 domain, same as CPU)
//  rst       in   1   asynchronous reset, active-high
//  ps2_clk   in   1   raw PS/2 clock pin (asynchronous)
//  ps2_data  in   1   raw PS/2 data pin (asynchronous)
//  STB       in   1   strobe from intercon; high for the whole transaction
//  WE        in   1   1 = write, 0 = read; valid while STB
//  ADDR      in   32  byte address; only ADDR[3:2] decoded
//  DAT_I     in   32  write data
//  DAT_O     out  32  read data; valid while ACK
//  ACK       out  1   transaction-complete pulse
//  irq       out  1   level: FIFO non-empty
// BEHAVIOUR
//  Reset: ACK=0, DAT_O=0, irq=0, FIFO empty, all status flags 0, receiver idle.
//  Input sync: ps2_clk/ps2_data through 2-flop synchronisers; falling edge = prev 1, cur 0 of synced clk.
//  Receiver FSM (sampled on each falling edge):
//   IDLE  : data=0 -> DATA (bit cnt 0); data=1 ignored (glitch).
//   DATA  : shift in LSB-first, 8 bits -> PARITY.
//   PARITY: capture bit -> STOP.
//   STOP  : data=1 and odd parity over 9 bits OK -> push byte; else set frame_err, no push. -> IDLE.
//   Any non-IDLE state: timeout counter resets on each falling edge; reaching TIMEOUT_CYCLES -> IDLE,
//   set frame_err, partial byte discarded.
//  FIFO: 2^FIFO_AW entries x 8 bit, count width FIFO_AW+1, pointers wrap modulo depth.
//   Push when full: byte dropped, overflow flag set. Pop when empty: no change.
//   Simultaneous push+pop: both occur, count unchanged (push to full FIFO with same-cycle pop is accepted).
//  Register map (ADDR[3:2]):
//   0 DATA   R: {valid,23'b0,byte}; valid=1 and pop when non-empty, else 32'h0. W: ignored.
//   1 STATUS R: {16'b0, 7'b0, count[FIFO_AW:0] zero-extended to 9b? no: bits[12:8]=count, 5'b0,
//            bit2 full, bit1 overflow, bit0 frame_err}. W: DAT_I[0]=1 clears both error flags,
//            DAT_I[1]=1 flushes FIFO (pointers/count -> 0).
//   2,3      R: 32'h0. W: ignored. Always ACKed (no bus hang).
//  Bus FSM: IDLE -(STB)-> RESP (1 cycle: ACK=1, DAT_O valid, side effects committed exactly once)
//   -> WAIT (ACK=0) until STB=0 -> IDLE. Latency: ACK in cycle after STB first sampled high.
//   Pop/clear/flush happen once per transaction even if STB held many cycles.
//  Flag set and software clear in same cycle: set wins.
//  Flush and receiver push in same cycle: flush wins, byte lost (no overflow).
//  rst mid-frame or mid-transaction: all state to reset values immediately; ACK drops asynchronously.
//  irq = (count != 0), registered.
// STRUCTURE
//  Shared package kbd_pkg: register offsets (KBD_DATA=2'd0, KBD_STATUS=2'd1), status bit indices,
//  receiver state enum (IDLE/DATA/PARITY/STOP), bus state enum (IDLE/RESP/WAIT).
//  One sub-module: ps2_frame_rx (synchronisers, edge detect, receiver FSM, timeout) -> outputs
//  byte_valid pulse, byte[7:0], frame_err pulse. FIFO and bus FSM inline in top.
// TESTING
//  1 Send frame 0x1C (start 0, bits LSB-first, parity 0, stop 1); read ADDR 0x0 -> ACK 1 cycle after
//    STB, DAT_O=32'h8000_001C; second read -> 32'h0; irq 1 then 0.
//  2 Send 0x1C with parity 1 -> no push, STATUS read = 32'h0000_0001; write STATUS DAT_I=1 -> 32'h0.
//  3 Send 17 bytes 0x01..0x11 without reading -> STATUS = 32'h0000_1006 (count 16, full, overflow);
//    16 DATA reads return 0x8000_0001..0x8000_0010, 0x11 lost.
//  4 Start frame, stop ps2_clk after 4 bits for 25000 cycles -> frame_err=1, receiver IDLE; next
//    full frame 0x5A received correctly.
//  5 Hold STB 10 cycles on DATA with 2 bytes queued -> single ACK, one pop, count 2->1.
//  6 Assert rst mid-frame and during RESP -> ACK=0, count=0, flags 0; subsequent frame 0x29 received.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: register offsets, status bit indices and FSM state types shared by the PS/2 keyboard slave
package kbd_pkg;
  localparam logic [1:0] KBD_DATA = 2'd0;
  localparam logic [1:0] KBD_STATUS = 2'd1;
  localparam int ST_FERR = 0;
  localparam int ST_OVF = 1;
  localparam int ST_FULL = 2;
  localparam int ST_COUNT = 8;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {BUS_IDLE, BUS_RESP, BUS_WAIT} bus_state_t;
endpackage

// File: rtl/wb_ps2_keyboard_if.sv
// wb_ps2_keyboard_if: STB/ACK bus bundle (STB, WE, ADDR, DAT_I from master; DAT_O, ACK from slave)
interface wb_ps2_keyboard_if;
  logic STB;
  logic WE;
  logic [31:0] ADDR;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic ACK;
  modport master(output STB, WE, ADDR, DAT_I, input DAT_O, ACK);
  modport slave(input STB, WE, ADDR, DAT_I, output DAT_O, ACK);
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 frame receiver; in clk, rst, ps2_clk, ps2_data; out byte_valid pulse, rx_byte, frame_err pulse
module ps2_frame_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [2:0] clk_s;
  logic [1:0] data_s;
  logic fall, d, par, tmo_hit;
  logic [2:0] bit_cnt;
  logic [TW-1:0] tmo;
  rx_state_t state, state_n;
  assign d = data_s[1];
  assign fall = clk_s[2] & ~clk_s[1];
  assign tmo_hit = state != RX_IDLE && !fall && tmo == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_n = state;
    byte_valid = 1'b0;
    frame_err = tmo_hit;
    if (tmo_hit) state_n = RX_IDLE;
    else if (fall)
      case (state)
        RX_IDLE: state_n = d ? RX_IDLE : RX_DATA;
        RX_DATA: state_n = bit_cnt == 3'd7 ? RX_PARITY : RX_DATA;
        RX_PARITY: state_n = RX_STOP;
        default: begin
          state_n = RX_IDLE;
          byte_valid = d && ^{rx_byte, par};
          frame_err = !byte_valid;
        end
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clk_s <= '1;
      data_s <= '1;
      state <= RX_IDLE;
      bit_cnt <= '0;
      par <= 1'b0;
      rx_byte <= '0;
      tmo <= '0;
    end else begin
      clk_s <= {clk_s[1:0], ps2_clk};
      data_s <= {data_s[0], ps2_data};
      state <= state_n;
      tmo <= (state == RX_IDLE || fall) ? '0 : tmo + 1'b1;
      if (fall && state == RX_DATA) begin
        rx_byte <= {d, rx_byte[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == RX_IDLE) bit_cnt <= '0;
      if (fall && state == RX_PARITY) par <= d;
    end
endmodule

// File: rtl/wb_ps2_keyboard.sv
// wb_ps2_keyboard: PS/2 keyboard bus slave with scan-code FIFO; in clk, rst, ps2_clk, ps2_data; bus slave modport; out irq (FIFO non-empty)
module wb_ps2_keyboard
  import kbd_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  wb_ps2_keyboard_if.slave bus,
  output logic             irq
);
  localparam int CW = FIFO_AW + 1;
  localparam int DEPTH = 1 << FIFO_AW;
  logic byte_valid, frame_err, full, empty, ovf, ferr;
  logic go, rd, wr, pop, push, flush, clr, unused;
  logic [7:0] rx_byte;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic [1:0] reg_sel;
  logic [31:0] rdata;
  bus_state_t bus_state, bus_state_n;
  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk, .rst, .ps2_clk, .ps2_data, .byte_valid, .rx_byte, .frame_err
  );
  assign unused = ^{bus.ADDR[31:4], bus.ADDR[1:0], bus.DAT_I[31:2]};
  assign full = count[FIFO_AW];
  assign empty = count == '0;
  assign reg_sel = bus.ADDR[3:2];
  assign go = bus_state == BUS_IDLE && bus.STB;
  assign rd = go && !bus.WE;
  assign wr = go && bus.WE && reg_sel == KBD_STATUS;
  assign pop = rd && reg_sel == KBD_DATA && !empty;
  assign flush = wr && bus.DAT_I[1];
  assign clr = wr && bus.DAT_I[0];
  assign push = byte_valid && (!full || pop) && !flush;
  assign count_n = flush ? '0 : count + CW'(push) - CW'(pop);
  assign rdata = reg_sel == KBD_DATA ? (empty ? '0 : {1'b1, 23'b0, mem[rd_ptr]})
               : reg_sel == KBD_STATUS ? (32'(count) << ST_COUNT) | (32'(full) << ST_FULL)
                                         | (32'(ovf) << ST_OVF) | (32'(ferr) << ST_FERR)
               : '0;
  assign bus.ACK = bus_state == BUS_RESP;
  always_comb
    bus_state_n = bus_state == BUS_IDLE ? (bus.STB ? BUS_RESP : BUS_IDLE)
                : bus_state == BUS_RESP ? BUS_WAIT
                : (bus.STB ? BUS_WAIT : BUS_IDLE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus_state <= BUS_IDLE;
      bus.DAT_O <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      ferr <= 1'b0;
      irq <= 1'b0;
    end else begin
      bus_state <= bus_state_n;
      bus.DAT_O <= rd ? rdata : '0;
      wr_ptr <= flush ? '0 : wr_ptr + FIFO_AW'(push);
      rd_ptr <= flush ? '0 : rd_ptr + FIFO_AW'(pop);
      count <= count_n;
      ovf <= (byte_valid && full && !pop && !flush) || (ovf && !clr);
      ferr <= frame_err || (ferr && !clr);
      irq <= count_n != '0;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= rx_byte;
endmodule

// File: tb/tb_wb_ps2_keyboard.sv
// tb_wb_ps2_keyboard: randomized and directed checks of wb_ps2_keyboard against a queue-based model
module tb_wb_ps2_keyboard;
  localparam int HALF = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic irq;
  wb_ps2_keyboard_if bus();
  wb_ps2_keyboard dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus), .irq(irq)
  );
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  logic m_ovf, m_ferr, settled, stb_q, e_ack, exp_rd;
  logic [31:0] exp_dat, got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    return (32'(q.size()) << 8) | {29'b0, q.size() == 16, m_ovf, m_ferr};
  endfunction

  function automatic logic [31:0] model_access(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    r = 32'h0;
    if (we) begin
      if (a[3:2] == 2'd1) begin
        if (d[0]) begin
          m_ovf = 1'b0;
          m_ferr = 1'b0;
        end
        if (d[1]) q.delete();
      end
    end else if (a[3:2] == 2'd0) begin
      if (q.size() != 0) r = {1'b1, 23'b0, q.pop_front()};
    end else if (a[3:2] == 2'd1) r = model_status();
    return r;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (q.size() < 16) q.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  // ACK is due exactly in the cycle after STB is first sampled high
  always @(posedge clk or posedge rst)
    if (rst) begin
      stb_q <= 1'b0;
      e_ack <= 1'b0;
    end else begin
      e_ack <= bus.STB && !stb_q;
      stb_q <= bus.STB;
    end

  always @(negedge clk)
    if (!rst) begin
      check("ack", bus.ACK, e_ack);
      if (e_ack && exp_rd) check("dat_o", bus.DAT_O, exp_dat);
      if (settled) check("irq", irq, q.size() != 0);
    end

  task automatic bus_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input int hold, output logic [31:0] r);
    @(negedge clk);
    settled = 1'b0;
    bus.STB = 1'b1;
    bus.WE = we;
    bus.ADDR = a;
    bus.DAT_I = d;
    exp_rd = !we;
    exp_dat = model_access(we, a, d);
    r = 32'hDEAD_BEEF;
    repeat (hold) begin
      @(negedge clk);
      if (bus.ACK) r = bus.DAT_O;
    end
    bus.STB = 1'b0;
    repeat (2) @(negedge clk);
    settled = 1'b1;
  endtask

  task automatic ps2_bits(input logic [7:0] b, input logic flip, input int n);
    logic [10:0] f;
    f = {1'b1, ~^b ^ flip, b, 1'b0};
    settled = 1'b0;
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic flip);
    ps2_bits(b, flip, 11);
    if (flip) m_ferr = 1'b1;
    else model_push(b);
    settled = 1'b1;
  endtask

  task automatic glitch();
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settled = 1'b1;
  endtask

  initial begin
    bus.STB = 1'b0;
    bus.WE = 1'b0;
    bus.ADDR = '0;
    bus.DAT_I = '0;
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    settled = 1'b0;
    exp_rd = 1'b0;
    exp_dat = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", bus.ACK, 0);
    check("rst_dat", bus.DAT_O, 0);
    check("rst_irq", irq, 0);
    rst = 1'b0;
    settled = 1'b1;
    bus_op(0, 32'h4, 0, 2, got); check("rst_status", got, 32'h0);

    send(8'h1C, 0);
    check("t1_irq", irq, 1);
    bus_op(0, 32'h0, 0, 2, got); check("t1_read", got, 32'h8000_001C);
    check("t1_irq_clr", irq, 0);
    bus_op(0, 32'h0, 0, 2, got); check("t1_empty", got, 32'h0);

    send(8'h1C, 1);
    bus_op(0, 32'h4, 0, 2, got); check("t2_status", got, 32'h1);
    bus_op(1, 32'h4, 1, 2, got);
    bus_op(0, 32'h4, 0, 2, got); check("t2_clear", got, 32'h0);

    for (int i = 1; i <= 17; i++) send(8'(i), 0);
    bus_op(0, 32'h4, 0, 2, got); check("t3_status", got, 32'h1006);
    for (int i = 1; i <= 16; i++) begin
      bus_op(0, 32'h0, 0, 2, got); check("t3_pop", got, 32'h8000_0000 | 32'(i));
    end
    bus_op(0, 32'h0, 0, 2, got); check("t3_lost", got, 32'h0);
    bus_op(1, 32'h4, 1, 2, got);

    ps2_bits(8'hA5, 0, 5);
    repeat (25100) @(negedge clk);
    m_ferr = 1'b1;
    settled = 1'b1;
    bus_op(0, 32'h4, 0, 2, got); check("t4_ferr", got, 32'h1);
    send(8'h5A, 0);
    bus_op(0, 32'h0, 0, 2, got); check("t4_byte", got, 32'h8000_005A);
    bus_op(1, 32'h4, 1, 2, got);

    send(8'h33, 0);
    send(8'h44, 0);
    bus_op(0, 32'h0, 0, 10, got); check("t5_pop", got, 32'h8000_0033);
    bus_op(0, 32'h4, 0, 2, got); check("t5_count", got, 32'h100);
    bus_op(1, 32'h4, 2, 2, got);
    bus_op(0, 32'h4, 0, 2, got); check("flush", got, 32'h0);

    ps2_bits(8'h77, 0, 5);
    do_reset();
    bus_op(0, 32'h4, 0, 2, got); check("t6_frame_rst", got, 32'h0);
    send(8'h12, 0);
    @(negedge clk);
    settled = 1'b0;
    bus.STB = 1'b1;
    bus.WE = 1'b0;
    bus.ADDR = 32'h0;
    exp_rd = 1'b1;
    exp_dat = 32'h8000_0012;
    @(posedge clk);
    #2;
    check("t6_resp_ack", bus.ACK, 1);
    rst = 1'b1;
    #1;
    check("t6_async_ack", bus.ACK, 0);
    check("t6_async_dat", bus.DAT_O, 0);
    check("t6_async_irq", irq, 0);
    bus.STB = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settled = 1'b1;
    bus_op(0, 32'h4, 0, 2, got); check("t6_status", got, 32'h0);
    send(8'h29, 0);
    bus_op(0, 32'h0, 0, 2, got); check("t6_byte", got, 32'h8000_0029);

    for (int n = 0; n < 150; n++) begin
      int op;
      logic [31:0] a, d;
      op = $urandom_range(0, 9);
      a = $urandom;
      d = $urandom;
      if (op <= 2) send(8'($urandom), $urandom_range(0, 7) == 0);
      else if (op == 3) glitch();
      else if (op <= 6) bus_op(0, a, 0, $urandom_range(1, 4), got);
      else if (op == 7) begin
        a[3:2] = $urandom_range(0, 7) == 0 ? 2'($urandom) : 2'd1;
        d[1] = $urandom_range(0, 5) == 0;
        bus_op(1, a, d, $urandom_range(1, 4), got);
      end else begin
        a[3:2] = 2'd0;
        bus_op(0, a, 0, $urandom_range(1, 4), got);
      end
    end
    exp_dat = model_status();
    bus_op(0, 32'h4, 0, 2, got); check("final_status", got, exp_dat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
